// File: rtl/uart_hex_byte_parser_pkg.sv
// Shared definitions for the UART hex byte parser.
//   - ASCII terminator constants
//   - parser state encoding
//   - character-class enum plus a helper that maps decoder flags to a class
package uart_hex_byte_parser_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        S_HI      = 2'd0,
        S_LO      = 2'd1,
        S_TERM    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HEX   = 2'd0,
        TERM  = 2'd1,
        OTHER = 2'd2
    } char_class_t;

    function automatic char_class_t classify(input logic is_hex, input logic is_term);
        if (is_hex) begin
            return HEX;
        end else if (is_term) begin
            return TERM;
        end
        return OTHER;
    endfunction

endpackage

// File: rtl/uart_hex_byte_parser_if.sv
// Byte stream interface between the UART receiver, the hex parser and the
// display/control consumer.
//   i_rx_valid     : receiver byte-valid level
//   i_rx_byte      : received byte
//   o_byte_valid   : one-cycle pulse per parsed command
//   o_byte         : last parsed byte
//   o_error        : one-cycle pulse per detected error
//   o_error_count  : saturating error count
// slave modport is the parser's view; master is the surrounding system's view.
interface uart_hex_byte_parser_if;

    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       o_byte_valid;
    logic [7:0] o_byte;
    logic       o_error;
    logic [7:0] o_error_count;

    modport slave (
        input  i_rx_valid,
        input  i_rx_byte,
        output o_byte_valid,
        output o_byte,
        output o_error,
        output o_error_count
    );

    modport master (
        output i_rx_valid,
        output i_rx_byte,
        input  o_byte_valid,
        input  o_byte,
        input  o_error,
        input  o_error_count
    );

endinterface

// File: rtl/uart_hex_byte_parser_hex_nibble_decode.sv
// Combinational ASCII decoder, shared with any future hex echo/transmit stage.
//   i_byte    : ASCII character
//   o_is_hex  : '0'-'9', 'A'-'F' or 'a'-'f'
//   o_is_term : CR or LF
//   o_nibble  : value of a hex character, 0 otherwise
module hex_nibble_decode
    import uart_hex_byte_parser_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic       o_is_term,
    output logic [3:0] o_nibble
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_is_hex = 1'b0;
        o_nibble = 4'd0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0];
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // Low nibble of 'A'/'a' is 1, so +9 lands on 10.
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0] + 4'd9;
        end
    end

    assign o_is_term = (i_byte == ASCII_CR) || (i_byte == ASCII_LF);

endmodule

// File: rtl/uart_hex_byte_parser.sv
// Assembles two ASCII hex digits followed by CR/LF into one binary byte.
//   i_clk   : system clock
//   i_reset : synchronous, active-high reset
//   bus     : slave side of uart_hex_byte_parser_if (rx level in, parsed
//             byte / valid pulse / error pulse / saturating error count out)
// A byte is accepted once per rising edge of the receiver's valid level.
// A stalled command (no accept for TIMEOUT_CYCLES clocks) is abandoned.
module uart_hex_byte_parser
    import uart_hex_byte_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    uart_hex_byte_parser_if.slave bus
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_prev_valid;
    logic [3:0]       r_hi;
    logic [3:0]       r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_byte;
    logic             r_byte_valid;
    logic             r_error;
    logic [7:0]       r_error_count;

    logic             w_is_hex;
    logic             w_is_term;
    logic [3:0]       w_nibble;
    char_class_t      w_class;
    logic             w_accept;
    logic             w_timeout;
    state_t           w_state_next;
    logic             w_load_hi;
    logic             w_load_lo;
    logic             w_emit;
    logic             w_raise;

    hex_nibble_decode u_decode (
        .i_byte    (bus.i_rx_byte),
        .o_is_hex  (w_is_hex),
        .o_is_term (w_is_term),
        .o_nibble  (w_nibble)
    );

    assign w_class  = classify(w_is_hex, w_is_term);
    assign w_accept = bus.i_rx_valid && !r_prev_valid;
    // An accept in the same cycle always beats the timeout.
    assign w_timeout = (r_state != S_HI) && !w_accept && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_load_hi    = 1'b0;
        w_load_lo    = 1'b0;
        w_emit       = 1'b0;
        w_raise      = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_HI: begin
                    if (w_class == HEX) begin
                        w_load_hi    = 1'b1;
                        w_state_next = S_LO;
                    end else if (w_class == OTHER) begin
                        w_raise      = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
                S_LO: begin
                    if (w_class == HEX) begin
                        w_load_lo    = 1'b1;
                        w_state_next = S_TERM;
                    end else if (w_class == TERM) begin
                        w_raise      = 1'b1;
                        w_state_next = S_HI;
                    end else begin
                        w_raise      = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
                S_TERM: begin
                    if (w_class == TERM) begin
                        w_emit       = 1'b1;
                        w_state_next = S_HI;
                    end else begin
                        w_raise      = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (w_class == TERM) begin
                        w_state_next = S_HI;
                    end
                end
                default: w_state_next = S_HI;
            endcase
        end else if (w_timeout) begin
            // A stalled discard ends silently; a stalled command is an error.
            w_state_next = S_HI;
            w_raise      = (r_state != S_DISCARD);
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_state       <= S_HI;
            r_prev_valid  <= 1'b1;  // a level held through reset is not a new byte
            r_hi          <= 4'd0;
            r_lo          <= 4'd0;
            r_cnt         <= '0;
            r_byte        <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_error       <= 1'b0;
            r_error_count <= 8'h00;
        end else begin
            r_prev_valid <= bus.i_rx_valid;
            r_state      <= w_state_next;
            if (w_load_hi) begin
                r_hi <= w_nibble;
            end
            if (w_load_lo) begin
                r_lo <= w_nibble;
            end
            if (w_accept || w_timeout || r_state == S_HI) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_byte_valid <= w_emit;
            r_error      <= w_raise;
            if (w_emit) begin
                r_byte <= {r_hi, r_lo};
            end
            if (w_raise && r_error_count != 8'hFF) begin
                r_error_count <= r_error_count + 8'd1;
            end
        end
    end

    assign bus.o_byte_valid  = r_byte_valid;
    assign bus.o_byte        = r_byte;
    assign bus.o_error       = r_error;
    assign bus.o_error_count = r_error_count;

endmodule

// File: tb/tb_uart_hex_byte_parser.sv
// Self-checking bench for uart_hex_byte_parser.
// Two instances share one stimulus: u_dut_fast (timeout 50 clocks) for most
// checks, u_dut_long (default timeout) for the long-hold command.
// In table text, '^' stands for CR and '~' for LF.
module tb_uart_hex_byte_parser;

    localparam int FAST_TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       tb_rst;
    logic       tb_valid;
    logic [7:0] tb_byte;

    always #5 clk = ~clk;

    uart_hex_byte_parser_if bus_fast ();
    uart_hex_byte_parser_if bus_long ();

    assign bus_fast.i_rx_valid = tb_valid;
    assign bus_fast.i_rx_byte  = tb_byte;
    assign bus_long.i_rx_valid = tb_valid;
    assign bus_long.i_rx_byte  = tb_byte;

    uart_hex_byte_parser #(.TIMEOUT_CYCLES(FAST_TIMEOUT)) u_dut_fast (
        .i_clk   (clk),
        .i_reset (tb_rst),
        .bus     (bus_fast)
    );

    uart_hex_byte_parser u_dut_long (
        .i_clk   (clk),
        .i_reset (tb_rst),
        .bus     (bus_long)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         f_nv = 0, f_ne = 0, l_nv = 0, l_ne = 0, both_cnt = 0;
    logic [7:0] f_last = 8'h00, l_last = 8'h00;
    int         evq[$];        // fast DUT events: byte value, or 256 for an error
    int         model_cnt;

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus_fast.o_byte_valid) begin
            f_nv++;
            f_last = bus_fast.o_byte;
            evq.push_back(int'(bus_fast.o_byte));
        end
        if (bus_fast.o_error) begin
            f_ne++;
            evq.push_back(256);
        end
        if (bus_fast.o_byte_valid && bus_fast.o_error) both_cnt++;
        if (bus_long.o_byte_valid) begin
            l_nv++;
            l_last = bus_long.o_byte;
        end
        if (bus_long.o_error) l_ne++;
        if (bus_long.o_byte_valid && bus_long.o_error) both_cnt++;
    end

    typedef struct {
        string      text;
        int         exp_valid;
        logic [7:0] exp_byte;
        int         exp_err;
    } vec_t;

    vec_t tab[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] b, input int hold, input int gap);
        tb_valid = 1'b1;
        tb_byte  = b;
        repeat (hold) @(negedge clk);
        tb_valid = 1'b0;
        tb_byte  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_text(input string s, input int hold, input int gap);
        logic [7:0] c;
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            if (c == 8'h5E) c = 8'h0D;
            else if (c == 8'h7E) c = 8'h0A;
            send_char(c, hold, gap);
        end
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic bit is_hex_char(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic int hex_val(input logic [7:0] b);
        if (b <= 8'h39) return int'(b) - 48;
        if (b <= 8'h46) return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    initial begin
        int         found;
        int         exp_q[$];
        logic [7:0] stream[$];
        logic [7:0] line[$];
        logic [7:0] b;
        string      hexchars;
        int         exp_errs;

        tb_rst   = 1'b1;
        tb_valid = 1'b0;
        tb_byte  = 8'h00;
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);

        check("reset o_byte_valid",  int'(bus_fast.o_byte_valid),  0);
        check("reset o_byte",        int'(bus_fast.o_byte),        0);
        check("reset o_error",       int'(bus_fast.o_error),       0);
        check("reset o_error_count", int'(bus_fast.o_error_count), 0);

        // ---------------- table-driven commands ----------------
        tab[0] = '{"A5^",  1, 8'hA5, 0};
        tab[1] = '{"3f~",  1, 8'h3F, 0};
        tab[2] = '{"00^",  1, 8'h00, 0};
        tab[3] = '{"G^",   0, 8'h00, 1};
        tab[4] = '{"12^",  1, 8'h12, 0};
        tab[5] = '{"7^",   0, 8'h00, 1};
        tab[6] = '{"CD^",  1, 8'hCD, 0};
        tab[7] = '{"^~",   0, 8'h00, 0};
        tab[8] = '{"5AB^", 0, 8'h00, 1};
        tab[9] = '{"1g^",  0, 8'h00, 1};

        model_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            f_nv = 0;
            f_ne = 0;
            send_text(tab[i].text, 20, 10);
            repeat (3) @(negedge clk);
            model_cnt += tab[i].exp_err;
            check($sformatf("tab[%0d] valid pulses", i), f_nv, tab[i].exp_valid);
            if (tab[i].exp_valid != 0)
                check($sformatf("tab[%0d] o_byte", i), int'(f_last), int'(tab[i].exp_byte));
            check($sformatf("tab[%0d] error pulses", i), f_ne, tab[i].exp_err);
            check($sformatf("tab[%0d] error_count", i), int'(bus_fast.o_error_count), model_cnt);
        end

        // ---------------- timeout in S_TERM ----------------
        f_nv = 0;
        f_ne = 0;
        send_char(8'h34, 20, 10);
        tb_valid = 1'b1;
        tb_byte  = 8'h32;
        @(posedge clk);                 // accept edge of '2'
        found = -1;
        for (int k = 1; k <= 200 && found < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 20) begin
                tb_valid = 1'b0;
                tb_byte  = 8'h00;
            end
            if (bus_fast.o_error) found = k;
        end
        tb_valid = 1'b0;
        tb_byte  = 8'h00;
        @(negedge clk);
        check("timeout error cycle", found, FAST_TIMEOUT);
        repeat (5) @(negedge clk);
        send_text("^", 20, 10);
        repeat (3) @(negedge clk);
        model_cnt += 1;
        check("after timeout valid pulses", f_nv, 0);
        check("after timeout error pulses", f_ne, 1);
        check("after timeout error_count", int'(bus_fast.o_error_count), model_cnt);

        // ---------------- reset mid-command ----------------
        send_char(8'h39, 5, 5);
        do_reset();
        f_nv = 0;
        f_ne = 0;
        send_text("^", 5, 5);
        repeat (3) @(negedge clk);
        check("mid reset valid pulses", f_nv, 0);
        check("mid reset error pulses", f_ne, 0);
        check("mid reset error_count", int'(bus_fast.o_error_count), 0);

        // ---------------- valid level held across reset ----------------
        tb_valid = 1'b1;
        tb_byte  = 8'h41;
        tb_rst   = 1'b1;
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        repeat (10) @(negedge clk);
        tb_valid = 1'b0;
        tb_byte  = 8'h00;
        repeat (10) @(negedge clk);
        check("held reset o_byte", int'(bus_fast.o_byte), 0);
        f_nv = 0;
        f_ne = 0;
        send_text("BC^", 5, 5);
        repeat (3) @(negedge clk);
        check("held reset valid pulses", f_nv, 1);
        check("held reset o_byte after BC", int'(f_last), 8'hBC);
        check("held reset error pulses", f_ne, 0);

        // ---------------- error counter saturation ----------------
        f_ne = 0;
        for (int i = 0; i < 300; i++) begin
            send_char(8'h47, 2, 2);
            send_char(8'h0D, 2, 2);
        end
        repeat (3) @(negedge clk);
        check("saturation error pulses", f_ne, 300);
        check("saturation error_count", int'(bus_fast.o_error_count), 8'hFF);

        // ---------------- randomized lines vs line-level model ----------------
        // A non-empty line is valid only if it is exactly two hex digits;
        // any other non-empty line yields exactly one error.
        do_reset();
        evq.delete();
        hexchars = "0123456789ABCDEFabcdef";
        exp_errs = 0;
        for (int n = 0; n < 120; n++) begin
            int len;
            line.delete();
            if ($urandom_range(0, 9) < 5) begin
                line.push_back(hexchars[$urandom_range(0, 21)]);
                line.push_back(hexchars[$urandom_range(0, 21)]);
            end else begin
                len = $urandom_range(0, 3);
                for (int j = 0; j < len; j++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        b = hexchars[$urandom_range(0, 21)];
                    end else begin
                        do b = 8'($urandom_range(0, 255));
                        while (is_hex_char(b) || b == 8'h0D || b == 8'h0A);
                    end
                    line.push_back(b);
                end
            end
            if (line.size() == 2 && is_hex_char(line[0]) && is_hex_char(line[1])) begin
                exp_q.push_back(hex_val(line[0]) * 16 + hex_val(line[1]));
            end else if (line.size() != 0) begin
                exp_q.push_back(256);
                exp_errs++;
            end
            foreach (line[j]) stream.push_back(line[j]);
            stream.push_back(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
        end
        foreach (stream[j]) send_char(stream[j], $urandom_range(1, 8), $urandom_range(1, 8));
        repeat (20) @(negedge clk);
        check("random event count", evq.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < evq.size(); j++)
            check($sformatf("random event[%0d]", j), evq[j], exp_q[j]);
        check("random error_count", int'(bus_fast.o_error_count),
              (exp_errs > 255) ? 255 : exp_errs);

        // ---------------- long-hold command (default timeout) ----------------
        do_reset();
        l_nv = 0;
        l_ne = 0;
        send_text("A5^", 107, 20);
        repeat (3) @(negedge clk);
        check("long hold valid pulses", l_nv, 1);
        check("long hold o_byte", int'(l_last), 8'hA5);
        check("long hold error pulses", l_ne, 0);

        check("valid and error same cycle", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
